// File: rtl/spart_pkg.sv
// Shared SPART definitions: receiver states, frame constants, register map.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int MIN_DIV   = 4;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // Divisors below the floor are too short to find mid-bit, so they are raised to it
  function automatic logic [15:0] clamp_div(input logic [15:0] divisor,
                                            input logic [15:0] min_div);
    return (divisor < min_div) ? min_div : divisor;
  endfunction

endpackage

// File: rtl/spart_rx_if.sv
// Bus-side view of the SPART receiver: divisor in, buffer and status out.
interface spart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [15:0]          divisor;
  logic                 rd_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output divisor,
    output rd_ack,
    input  rx_data,
    input  rda,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  divisor,
    input  rd_ack,
    output rx_data,
    output rda,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/spart_bit_timer.sv
// Loadable 16-bit down-counter that paces bit sampling; tick is high while it sits at zero.
module spart_bit_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        tick
);
  logic [15:0] cnt;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 16'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign tick = (cnt == 16'd0);
endmodule

// File: rtl/spart_rx.sv
// SPART receive engine: recovers 8N1 frames from rxd and presents bytes with rda/error flags.
module spart_rx #(
  parameter int DATA_BITS = spart_pkg::DATA_BITS,
  parameter int MIN_DIV   = spart_pkg::MIN_DIV
) (
  input logic       clk,
  input logic       rst,
  input logic       rxd,
  spart_rx_if.slave bus
);
  import spart_pkg::*;

  localparam int BW = $clog2(DATA_BITS);

  logic                 sync1;
  logic                 rxs;
  rx_state_t            state;
  rx_state_t            state_next;
  logic [15:0]          d_eff;
  logic [15:0]          div_q;
  logic                 tick;
  logic                 timer_load;
  logic [15:0]          timer_val;
  logic                 latch_div;
  logic                 clr_bit;
  logic                 shift_en;
  logic                 done_ok;
  logic                 done_err;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rda_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  assign d_eff = clamp_div(bus.divisor, 16'(MIN_DIV));

  spart_bit_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .tick     (tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control strobes; half a bit to the start centre, then whole bits
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_val  = 16'd0;
    latch_div  = 1'b0;
    clr_bit    = 1'b0;
    shift_en   = 1'b0;
    done_ok    = 1'b0;
    done_err   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          timer_load = 1'b1;
          timer_val  = d_eff >> 1;
          latch_div  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (!rxs) begin
            state_next = DATA;
            timer_load = 1'b1;
            timer_val  = div_q - 16'd1;
            clr_bit    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en   = 1'b1;
          timer_load = 1'b1;
          timer_val  = div_q - 16'd1;
          if (bitcnt == BW'(DATA_BITS - 1)) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (rxs) begin
            done_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            done_err   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Frame datapath: divisor captured per frame, bit counter, LSB-first shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= 16'd0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      if (latch_div) begin
        div_q <= d_eff;
      end
      if (clr_bit) begin
        bitcnt <= '0;
      end else if (shift_en) begin
        bitcnt <= bitcnt + BW'(1);
      end
      if (shift_en) begin
        shreg <= {rxs, shreg[DATA_BITS-1:1]};
      end
    end
  end

  // Bus-visible buffer and flags; a completing frame overrides a simultaneous read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_q   <= '0;
      rda_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (bus.rd_ack) begin
        rda_q       <= 1'b0;
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      if (done_ok) begin
        rx_data_q <= shreg;
        rda_q     <= 1'b1;
        if (rda_q && !bus.rd_ack) begin
          overrun_q <= 1'b1;
        end
      end
      if (done_err) begin
        frame_err_q <= 1'b1;
      end
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rda       = rda_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule
